// File: rtl/mips_pkg.sv
// Shared constants for the integer datapath: register file geometry and the
// hard-wired zero register.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering ALU writeback entries; head is visible
// combinationally and a pushed entry is poppable from the following cycle.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register file write-port owner: merges load and buffered ALU results (load
// priority, starvation guard) and tracks pending writes for RAW detection.
module regfile_writeback #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] query_rs,
  input  logic [ADDR_W-1:0] query_rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W-1:0] rd,
  output logic              regWrite,
  output logic [DATA_W-1:0] writeData
);
  import mips_pkg::*;

  localparam int ENT_W = DATA_W + ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              ld_win;
  logic              force_alu;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  starve_cnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign {head_rd, head_data} = head;

  assign force_alu = (starve_cnt == CNT_W'(STARVE_MAX)) && !fifo_empty;
  assign ld_ready  = !force_alu;
  assign alu_ready = !fifo_full;
  assign ld_win    = ld_valid && ld_ready;
  assign pop       = !ld_win && !fifo_empty;
  assign push      = alu_valid && !fifo_full;

  wb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({alu_rd, alu_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Results for $0 are consumed but never reach the register file.
  always_comb begin
    sel_vld  = 1'b0;
    sel_rd   = head_rd;
    sel_data = head_data;
    if (ld_win) begin
      sel_vld  = (ld_rd != ZERO);
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end else if (pop) begin
      sel_vld  = (head_rd != ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      regWrite  <= 1'b0;
      writeData <= '0;
    end else begin
      regWrite <= sel_vld;
      if (sel_vld) begin
        rd        <= sel_rd;
        writeData <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (ld_win) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    busy_nxt = busy;
    if (regWrite)    busy_nxt[rd]       = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs_busy = busy[query_rs];
  assign rt_busy = busy[query_rt];
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback with a queue-based
// reference model and a scoreboard monitor on the register file write port.
module tb_regfile_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int SM = 3;

  logic          clk;
  logic          rst_n;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          issue_valid;
  logic [AW-1:0] issue_rd, query_rs, query_rt;
  logic          rs_busy, rt_busy;
  logic [AW-1:0] rd;
  logic          regWrite;
  logic [DW-1:0] writeData;

  regfile_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_rs(query_rs), .query_rt(query_rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rd(rd), .regWrite(regWrite), .writeData(writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; int cyc; } wr_t;

  ent_t          alu_q[$];
  wr_t           exp_q[$];
  bit            mbusy[32];
  int            starve;
  bit            cur_vld;
  logic [AW-1:0] cur_rd;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle out of reset, the write port must match the scoreboard.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        chk("regWrite", 64'(regWrite), 64'(1));
        chk("rd", 64'(rd), 64'(mon_e.rd));
        chk("writeData", 64'(writeData), 64'(mon_e.data));
      end else begin
        chk("idle_regWrite", 64'(regWrite), 64'(0));
      end
    end
  end

  task automatic model_clear();
    alu_q.delete();
    exp_q.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    starve  = 0;
    cur_vld = 1'b0;
    cur_rd  = '0;
  endtask

  // One clock of stimulus: drive, predict the handshake at the coming edge, advance.
  task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                      input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                      input bit iv, input logic [AW-1:0] ird,
                      input logic [AW-1:0] qs, input logic [AW-1:0] qt);
    bit            m_alu_rdy, m_ld_rdy, win, had, nv;
    logic [AW-1:0] nrd;
    logic [DW-1:0] ndat;
    ent_t          e;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    issue_valid = iv; issue_rd = ird; query_rs = qs; query_rt = qt;
    #1;
    m_alu_rdy = (alu_q.size() < FD);
    m_ld_rdy  = !(starve == SM && alu_q.size() > 0);
    chk("alu_ready", 64'(alu_ready), 64'(m_alu_rdy));
    chk("ld_ready", 64'(ld_ready), 64'(m_ld_rdy));
    chk("rs_busy", 64'(rs_busy), 64'(mbusy[qs]));
    chk("rt_busy", 64'(rt_busy), 64'(mbusy[qt]));
    win  = lv && m_ld_rdy;
    had  = (alu_q.size() > 0);
    nv   = 1'b0;
    nrd  = '0;
    ndat = '0;
    if (win) begin
      nv = (lrd != 0); nrd = lrd; ndat = ldat;
      starve = had ? starve + 1 : 0;
    end else if (had) begin
      e = alu_q.pop_front();
      nv = (e.rd != 0); nrd = e.rd; ndat = e.data;
      starve = 0;
    end else begin
      starve = 0;
    end
    if (nv) exp_q.push_back('{nrd, ndat, cyc + 1});
    if (av && m_alu_rdy) alu_q.push_back('{ard, adat});
    if (cur_vld) mbusy[cur_rd] = 1'b0;
    if (iv && ird != 0) mbusy[ird] = 1'b1;
    cur_vld = nv;
    cur_rd  = nrd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, '0, '0, 0, '0, '0, 0, '0, AW'($urandom), AW'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid = 0; ld_valid = 0; issue_valid = 0;
    query_rs = 5'd7; query_rt = 5'd12;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 64'(regWrite), 64'(0));
    chk("rst_rd", 64'(rd), 64'(0));
    chk("rst_writeData", 64'(writeData), 64'(0));
    chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    chk("rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("rst_rs_busy", 64'(rs_busy), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    issue_valid = 0; issue_rd = '0; query_rs = '0; query_rt = '0;
    do_reset();

    // Single load: written exactly one cycle after acceptance.
    idle(1);
    step(0, '0, '0, 1, 5'd1, 32'd9, 0, '0, 5'd1, 5'd0);
    idle(3);

    // Back-to-back ALU results, no loads.
    for (int i = 0; i < 4; i++)
      step(1, AW'(5 + i), DW'(100 + i), 0, '0, '0, 0, '0, '0, '0);
    idle(4);

    // ALU results offered under continuous loads: FIFO fills, push refused when full.
    for (int i = 0; i < 6; i++)
      step(1, AW'(5 + i), DW'(200 + i), 1, AW'(20 + i), DW'(300 + i), 0, '0, '0, '0);
    idle(8);

    // Starvation guard: one queued ALU result vs. a continuous load stream.
    step(1, 5'd4, 32'd44, 1, 5'd21, 32'd500, 0, '0, '0, '0);
    for (int i = 0; i < 6; i++)
      step(0, '0, '0, 1, 5'd22, DW'(501 + i), 0, '0, '0, '0);
    idle(3);

    // Scoreboard: set, clear by load, and set racing a clear.
    step(0, '0, '0, 0, '0, '0, 1, 5'd7, 5'd7, 5'd7);
    step(0, '0, '0, 1, 5'd7, 32'd77, 0, '0, 5'd7, 5'd0);
    idle(1);
    step(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, 5'd7);
    step(0, '0, '0, 0, '0, '0, 1, 5'd7, 5'd7, 5'd7);
    step(0, '0, '0, 1, 5'd7, 32'd78, 0, '0, 5'd7, 5'd7);
    step(0, '0, '0, 0, '0, '0, 1, 5'd7, 5'd7, 5'd7);
    step(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, 5'd7);
    step(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, 5'd7);

    // Destination $0: consumed silently, never busy.
    step(1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0, 1, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      step(0, '0, '0, 0, '0, '0, 0, '0, 5'd0, 5'd0);

    // Mid-operation reset with three queued ALU results and busy registers.
    for (int i = 0; i < 3; i++)
      step(1, AW'(10 + i), DW'(600 + i), 1, AW'(25 + i), DW'(700 + i), 1, AW'(10 + i), 5'd10, 5'd11);
    query_rs = 5'd10; query_rt = 5'd11;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_regWrite", 64'(regWrite), 64'(0));
    chk("arst_alu_ready", 64'(alu_ready), 64'(1));
    chk("arst_rs_busy", 64'(rs_busy), 64'(0));
    chk("arst_rt_busy", 64'(rt_busy), 64'(0));
    do_reset();
    idle(6);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++)
      step(bit'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom),
           bit'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom));
    idle(10);
    chk("drain_expected", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Drives the single write port of the 32x32 register file (`rd`, `regWrite`, `writeData`).
- Merges writeback results from two producers with valid/ready handshakes:
  - the ALU, which is buffered in a small FIFO;
  - the load unit, which has priority with a starvation guard.
- Keeps a per-register pending-write scoreboard that decode queries with `rs`/`rt` to detect RAW hazards.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)
- FIFO_DEPTH, 4, ALU result FIFO entries (power of two, >=2)
- STARVE_MAX, 3, consecutive load wins before the ALU FIFO is forced through

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted when valid&ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when valid&ready
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- issue_valid  in  1  decode issued an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of issued instruction
- query_rs  in  ADDR_W  decode source register 1
- query_rt  in  ADDR_W  decode source register 2
- rs_busy  out  1  write pending to query_rs (combinational)
- rt_busy  out  1  write pending to query_rt (combinational)
- rd  out  ADDR_W  register file write address (registered)
- regWrite  out  1  register file write enable (registered)
- writeData  out  DATA_W  register file write data (registered)

Behaviour:
- Clock is `clk`. Reset is `rst_n`: asynchronous, active-low, one clock domain.
- Reset state:
  - FIFO empty; starve_cnt=0; busy[31:0]=0.
  - rd=0, regWrite=0, writeData=0.
  - alu_ready=1, ld_ready=1.
  - No handshake completes while rst_n=0.
- Reset asserted mid-operation discards FIFO contents, the in-flight output write and all busy bits immediately.
- ALU path:
  - alu_ready = !fifo_full. A push is refused when full, even if a pop happens the same cycle.
  - A push in cycle N can pop no earlier than N+1. There is no bypass.
- Load path: accept in cycle N gives regWrite=1 in N+1 with rd=ld_rd and writeData=ld_data.
- Port arbitration, evaluated each cycle:
  - if ld_valid&ld_ready, the load wins;
  - else, if the FIFO is not empty, pop the head.
  - A pop in cycle N gives regWrite=1 in N+1.
  - At most one write per cycle. regWrite=0 when nothing is selected; rd and writeData hold their last values.
- Starvation guard:
  - starve_cnt increments when the FIFO is non-empty and the load wins.
  - It clears on any FIFO pop or when the FIFO is empty.
  - ld_ready = !(starve_cnt==STARVE_MAX && !fifo_empty). The FIFO pops that cycle.
- Register $0:
  - Results with destination 0 are accepted and popped normally, but regWrite stays 0 for that slot.
  - busy[0] is constantly 0.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - A completed write (regWrite=1 in cycle N+1) clears busy[rd] at the end of that cycle.
  - If a set and a clear target the same register in the same cycle, the set wins.
  - rs_busy=busy[query_rs] and rt_busy=busy[query_rt], purely combinational.
- FIFO pointers use ADDR bits plus one wrap bit; full/empty come from pointer compare. Wrap-around past FIFO_DEPTH must preserve order.

Decomposition:
- Shared package `mips_pkg` holds:
  - REG_ADDR_W=5 and DATA_W=32;
  - REG_ZERO=5'd0.
- Natural sub-module: `wb_fifo`, a parameterised synchronous FIFO (DATA_W+ADDR_W wide, depth FIFO_DEPTH) with push/pop/full/empty, async active-low reset.
- Arbitration, starvation counter, output register and scoreboard stay in regfile_writeback.

Test Plan:
- Reset, then a single load (ld_rd=1, ld_data=9) accepted at cycle 2 -> regWrite=1, rd=1, writeData=9 in cycle 3 only.
- ALU writes 5,6,7,8 (data 100+i) back-to-back with no loads -> alu_ready drops after the 4th push if no pop has happened. Writes appear in order 5,6,7,8, each two cycles after its push at the earliest.
- ALU result rd=4 queued while ld_valid is held high continuously:
  - the load wins 3 cycles;
  - the 4th cycle has ld_ready=0 and the FIFO pops;
  - regWrite with rd=4 appears the next cycle.
- issue_valid rd=7, then query_rs=7 -> rs_busy=1. A load to r7 gives rs_busy=0 the cycle after regWrite. Set and clear of r7 in the same cycle -> rs_busy stays 1.
- ALU result with alu_rd=0, data 0xFFFFFFFF -> accepted and popped, regWrite never asserted, rs_busy for query_rs=0 always 0.
- rst_n pulled low with 3 FIFO entries and busy bits set -> regWrite=0, alu_ready=1, all busy=0 immediately (asynchronously), and no stale write after release.
